// File: rtl/alarm_ring_ctrl.sv
// alarm_ring_ctrl: alarm sequencer driving buzzer beeps, stop/snooze handling and auto-silence.
module alarm_ring_ctrl #(
   parameter int RING_TIMEOUT_S = 60,
   parameter int SNOOZE_S       = 300,
   parameter int SNOOZE_MAX     = 3,
   parameter int TW             = 9
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          tick_1hz,
   input  logic          tick_beep,
   input  logic          flag_alarm,
   input  logic          alarm_armed,
   input  logic          snooze_press,
   input  logic          stop_press,
   output logic          buzzer,
   output logic          ringing,
   output logic          snoozing,
   output logic [TW-1:0] snooze_left,
   output logic [1:0]    snooze_used
);
   typedef enum logic [1:0] {IDLE, RINGING, SNOOZE} state_t;
   localparam logic [TW-1:0] RING_LAST   = TW'(RING_TIMEOUT_S - 1);
   localparam logic [TW-1:0] SNOOZE_INIT = TW'(SNOOZE_S);
   localparam logic [1:0]    USED_MAX    = 2'(SNOOZE_MAX);
   state_t state, state_n;
   logic flag_prev, trigger, beep_phase, beep_n, buzzer_n;
   logic [TW-1:0] ring_cnt, ring_n, left_n;
   logic [1:0] used_n;
   assign trigger  = flag_alarm & ~flag_prev;
   assign ringing  = state == RINGING;
   assign snoozing = state == SNOOZE;
   always_comb begin
      state_n = state;
      ring_n  = ring_cnt;
      left_n  = snooze_left;
      used_n  = snooze_used;
      beep_n  = beep_phase;
      if (!alarm_armed)
         state_n = IDLE;
      else if (state == IDLE) begin
         if (trigger) state_n = RINGING;
      end else if (state == RINGING) begin
         if (stop_press)
            state_n = IDLE;
         else if (snooze_press && snooze_used < USED_MAX) begin
            state_n = SNOOZE;
            used_n  = snooze_used + 2'd1;
            left_n  = SNOOZE_INIT;
         end else if (tick_1hz && ring_cnt == RING_LAST)
            state_n = IDLE;
         else begin
            ring_n = (tick_1hz && ring_cnt != RING_LAST) ? ring_cnt + TW'(1) : ring_cnt;
            beep_n = tick_beep ? ~beep_phase : beep_phase;
         end
      end else begin
         if (stop_press)
            state_n = IDLE;
         else if (tick_1hz && snooze_left == TW'(1)) begin
            state_n = RINGING;
            left_n  = '0;
         end else if (tick_1hz && snooze_left != '0)
            left_n = snooze_left - TW'(1);
      end
      // Entry side effects are applied last so every path into a state gets them.
      if (state_n == IDLE) used_n = '0;
      if (state_n != SNOOZE) left_n = '0;
      if (state_n == RINGING && state != RINGING) begin
         ring_n = '0;
         beep_n = 1'b1;
      end
      buzzer_n = (state_n == RINGING) & beep_n;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         flag_prev   <= 1'b0;
         beep_phase  <= 1'b0;
         ring_cnt    <= '0;
         snooze_left <= '0;
         snooze_used <= '0;
         buzzer      <= 1'b0;
      end else begin
         state       <= state_n;
         flag_prev   <= flag_alarm;
         beep_phase  <= beep_n;
         ring_cnt    <= ring_n;
         snooze_left <= left_n;
         snooze_used <= used_n;
         buzzer      <= buzzer_n;
      end
   end
endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// tb_alarm_ring_ctrl: directed scoreboard bench for alarm_ring_ctrl.
module tb_alarm_ring_ctrl;
   logic clk = 1'b0;
   logic reset, tick_1hz, tick_beep, flag_alarm, alarm_armed, snooze_press, stop_press;
   logic buzzer, ringing, snoozing;
   logic [8:0] snooze_left;
   logic [1:0] snooze_used;
   int checks = 0;
   int errors = 0;
   typedef struct {
      string tag;
      logic r, s, b;
      logic [8:0] left;
      logic [1:0] used;
   } exp_t;
   exp_t q[$];
   alarm_ring_ctrl dut (
      .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .tick_beep(tick_beep),
      .flag_alarm(flag_alarm), .alarm_armed(alarm_armed), .snooze_press(snooze_press),
      .stop_press(stop_press), .buzzer(buzzer), .ringing(ringing), .snoozing(snoozing),
      .snooze_left(snooze_left), .snooze_used(snooze_used)
   );
   always #5 clk = ~clk;
   task automatic expect_out(input string tag, input logic r, input logic s, input logic b,
                             input logic [8:0] l, input logic [1:0] u);
      exp_t e;
      e.tag = tag; e.r = r; e.s = s; e.b = b; e.left = l; e.used = u;
      q.push_back(e);
   endtask
   task automatic step();
      exp_t e;
      @(posedge clk);
      #1;
      while (q.size() > 0) begin
         e = q.pop_front();
         checks++;
         assert ({ringing, snoozing, buzzer, snooze_left, snooze_used} === {e.r, e.s, e.b, e.left, e.used})
         else begin
            errors++;
            $error("FAIL %s: got ring=%b snz=%b buz=%b left=%0d used=%0d, expected ring=%b snz=%b buz=%b left=%0d used=%0d",
                   e.tag, ringing, snoozing, buzzer, snooze_left, snooze_used, e.r, e.s, e.b, e.left, e.used);
         end
      end
      tick_1hz = 0; tick_beep = 0; snooze_press = 0; stop_press = 0;
   endtask
   task automatic trigger(input string tag);
      flag_alarm = 0;
      step();
      flag_alarm = 1;
      expect_out(tag, 1, 0, 1, 0, 0);
      step();
   endtask
   task automatic snooze_round(input logic [1:0] u);
      snooze_press = 1;
      expect_out("snooze_enter", 0, 1, 0, 300, u);
      step();
      for (int i = 1; i <= 300; i++) begin
         tick_1hz = 1;
         if (i == 299) expect_out("snooze_last_sec", 0, 1, 0, 1, u);
         if (i == 300) expect_out("snooze_rering", 1, 0, 1, 0, u);
         step();
      end
   endtask
   initial begin
      reset = 1; tick_1hz = 0; tick_beep = 0; flag_alarm = 0; alarm_armed = 0;
      snooze_press = 0; stop_press = 0;
      expect_out("reset", 0, 0, 0, 0, 0);
      step();
      step();
      reset = 0; alarm_armed = 1;
      for (int i = 0; i < 8; i++) begin
         if (i == 7) expect_out("idle_wait", 0, 0, 0, 0, 0);
         step();
      end
      flag_alarm = 1;
      expect_out("ring_start", 1, 0, 1, 0, 0);
      step();
      tick_beep = 1;
      expect_out("beep_toggle0", 1, 0, 0, 0, 0);
      step();
      expect_out("beep_hold", 1, 0, 0, 0, 0);
      step();
      tick_beep = 1;
      expect_out("beep_toggle1", 1, 0, 1, 0, 0);
      step();
      for (int i = 0; i < 59; i++) begin
         tick_1hz = 1;
         if (i == 58) expect_out("ring_59s", 1, 0, 1, 0, 0);
         step();
      end
      tick_1hz = 1;
      expect_out("timeout", 0, 0, 0, 0, 0);
      step();
      expect_out("no_retrigger", 0, 0, 0, 0, 0);
      step();
      trigger("ring_t3");
      flag_alarm = 0;
      snooze_press = 1;
      expect_out("snooze1", 0, 1, 0, 300, 1);
      step();
      tick_1hz = 1;
      expect_out("snooze_dec", 0, 1, 0, 299, 1);
      step();
      snooze_press = 1;
      expect_out("snooze_in_snooze", 0, 1, 0, 299, 1);
      step();
      for (int i = 2; i <= 300; i++) begin
         tick_1hz = 1;
         if (i == 300) expect_out("rering1", 1, 0, 1, 0, 1);
         step();
      end
      snooze_round(2);
      snooze_round(3);
      snooze_press = 1;
      expect_out("snooze_exhausted", 1, 0, 1, 0, 3);
      step();
      stop_press = 1;
      expect_out("stop_clears_used", 0, 0, 0, 0, 0);
      step();
      trigger("ring_bound");
      for (int i = 0; i < 59; i++) begin
         tick_1hz = 1;
         step();
      end
      tick_1hz = 1; snooze_press = 1;
      expect_out("snooze_beats_timeout", 0, 1, 0, 300, 1);
      step();
      for (int i = 0; i < 299; i++) begin
         tick_1hz = 1;
         step();
      end
      tick_1hz = 1; stop_press = 1;
      expect_out("stop_beats_expiry", 0, 0, 0, 0, 0);
      step();
      trigger("ring_t5");
      stop_press = 1; snooze_press = 1;
      expect_out("stop_beats_snooze", 0, 0, 0, 0, 0);
      step();
      trigger("ring_t5b");
      snooze_press = 1;
      expect_out("snooze_t5", 0, 1, 0, 300, 1);
      step();
      alarm_armed = 0;
      expect_out("disarm_snooze", 0, 0, 0, 0, 0);
      step();
      flag_alarm = 0;
      step();
      flag_alarm = 1;
      expect_out("disarmed_no_trigger", 0, 0, 0, 0, 0);
      step();
      alarm_armed = 1;
      expect_out("arm_no_edge", 0, 0, 0, 0, 0);
      step();
      trigger("ring_t6");
      reset = 1; flag_alarm = 0;
      expect_out("reset_mid_ring", 0, 0, 0, 0, 0);
      step();
      reset = 0;
      expect_out("after_reset", 0, 0, 0, 0, 0);
      step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
